// File: rtl/acp_mm2s_pkg.sv
// Shared definitions for the ACP MM2S datamover engine: command/status field
// offsets, AXI read response codes and FSM state encodings.
package acp_mm2s_pkg;

    localparam int CMD_BTT_LSB   = 0;
    localparam int CMD_BTT_W     = 23;
    localparam int CMD_TYPE_BIT  = 23;
    localparam int CMD_EOF_BIT   = 30;
    localparam int CMD_SADDR_LSB = 32;
    localparam int CMD_TAG_LSB   = 64;
    localparam int CMD_TAG_W     = 4;

    localparam int STS_TAG_LSB    = 0;
    localparam int STS_INTERR_BIT = 4;
    localparam int STS_DECERR_BIT = 5;
    localparam int STS_SLVERR_BIT = 6;
    localparam int STS_OKAY_BIT   = 7;

    localparam logic [1:0] RRESP_OKAY   = 2'b00;
    localparam logic [1:0] RRESP_EXOKAY = 2'b01;
    localparam logic [1:0] RRESP_SLVERR = 2'b10;
    localparam logic [1:0] RRESP_DECERR = 2'b11;

    // Enumerated FSM states kept as plain constants for legacy tools.
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CALC = 3'd1;
    localparam logic [2:0] ST_ADDR = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_STS  = 3'd4;

    // ceil((2^23-1)/8) needs 21 bits.
    localparam int BEATS_W = 21;

    function automatic logic [7:0] sts_pack(input logic [CMD_TAG_W-1:0] tag,
                                            input logic interr,
                                            input logic decerr,
                                            input logic slverr);
        logic [7:0] s;
        s = 8'h00;
        s[STS_TAG_LSB +: CMD_TAG_W] = tag;
        s[STS_INTERR_BIT] = interr;
        s[STS_DECERR_BIT] = decerr;
        s[STS_SLVERR_BIT] = slverr;
        s[STS_OKAY_BIT]   = ~(interr | decerr | slverr);
        return s;
    endfunction

endpackage

// File: rtl/acp_burst_calc.sv
// Burst length for the next AR: the smallest of the burst cap, the beats still
// owed to the command, and the beats left before the next 4 KB boundary.
module acp_burst_calc
    import acp_mm2s_pkg::*;
#(
    parameter int C_MAX_BURST = 16
) (
    input  logic [BEATS_W-1:0] remaining,
    input  logic [8:0]         addr_beat,
    output logic [4:0]         len
);

    logic [9:0] page_beats;

    always_comb begin
        page_beats = 10'd512 - {1'b0, addr_beat};
        len = (remaining < BEATS_W'(C_MAX_BURST)) ? remaining[4:0] : 5'(C_MAX_BURST);
        if (page_beats < 10'(len)) begin
            len = page_beats[4:0];
        end
    end

endmodule

// File: rtl/acp_mm2s_engine.sv
// Command-driven MM2S engine: datamover commands in, ACP AXI3 reads, 64-bit stream
// and 8-bit status out. Define ACP_MM2S_PARTIAL_EN to allow BTT not a multiple of 8.
module acp_mm2s_engine
    import acp_mm2s_pkg::*;
#(
    parameter int         C_M_AXI_ADDR_WIDTH = 32,
    parameter int         C_M_AXI_DATA_WIDTH = 64,
    parameter int         C_MAX_BURST        = 16,
    parameter logic [2:0] C_PROT             = 3'b010,
    parameter logic [3:0] C_CACHE            = 4'b0011
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [71:0]                   S_AXIS_CMD_TDATA,
    input  logic                          S_AXIS_CMD_TVALID,
    output logic                          S_AXIS_CMD_TREADY,
    output logic [7:0]                    M_AXIS_STS_TDATA,
    output logic                          M_AXIS_STS_TVALID,
    input  logic                          M_AXIS_STS_TREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [7:0]                    M_AXI_ARLEN,
    output logic [2:0]                    M_AXI_ARSIZE,
    output logic [1:0]                    M_AXI_ARBURST,
    output logic [2:0]                    M_AXI_ARPROT,
    output logic [3:0]                    M_AXI_ARCACHE,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RLAST,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic [7:0]                    M_AXIS_TKEEP,
    output logic                          M_AXIS_TLAST,
    output logic                          M_AXIS_TVALID,
    input  logic                          M_AXIS_TREADY
);

    logic [2:0]                    state, state_nxt;
    logic                          cmd_ready_q;
    logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q, araddr_q;
    logic [BEATS_W-1:0]            rem_q, cmd_beats;
    logic [CMD_TAG_W-1:0]          tag_q;
    logic                          eof_q, bad_q, interr_q, slverr_q, decerr_q;
    logic [4:0]                    len_q, len_calc;
    logic [7:0]                    arlen_q;
    logic [CMD_BTT_W-1:0]          cmd_btt;
    logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_saddr;
    logic                          cmd_bad, cmd_fire, r_fire, last_beat;
    logic                          unused_cmd;
`ifdef ACP_MM2S_PARTIAL_EN
    logic [2:0]                    btt_lo_q;
`endif

    assign cmd_btt    = S_AXIS_CMD_TDATA[CMD_BTT_LSB +: CMD_BTT_W];
    assign cmd_saddr  = S_AXIS_CMD_TDATA[CMD_SADDR_LSB +: C_M_AXI_ADDR_WIDTH];
    assign cmd_beats  = BEATS_W'((24'(cmd_btt) + 24'd7) >> 3);
    assign unused_cmd = ^{S_AXIS_CMD_TDATA[71:68], S_AXIS_CMD_TDATA[31], S_AXIS_CMD_TDATA[29:23]};

    always_comb begin
        cmd_bad = (cmd_btt == '0) || (cmd_saddr[2:0] != 3'b000);
`ifdef ACP_MM2S_PARTIAL_EN
        cmd_bad = cmd_bad;
`else
        cmd_bad = cmd_bad || (cmd_btt[2:0] != 3'b000);
`endif
    end

    // Handshakes: a transfer happens on a rising edge where VALID and READY are both 1.
    assign cmd_fire  = S_AXIS_CMD_TVALID && cmd_ready_q;
    assign r_fire    = (state == ST_DATA) && M_AXI_RVALID && M_AXIS_TREADY;
    assign last_beat = (rem_q == BEATS_W'(1));

    acp_burst_calc #(.C_MAX_BURST(C_MAX_BURST)) u_burst_calc (
        .remaining (rem_q),
        .addr_beat (addr_q[11:3]),
        .len       (len_calc)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (cmd_fire) state_nxt = ST_CALC;
            ST_CALC: state_nxt = bad_q ? ST_STS : ST_ADDR;
            ST_ADDR: if (M_AXI_ARREADY) state_nxt = ST_DATA;
            ST_DATA: if (r_fire && M_AXI_RLAST) state_nxt = last_beat ? ST_STS : ST_CALC;
            ST_STS:  if (M_AXIS_STS_TREADY) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            addr_q      <= '0;
            araddr_q    <= '0;
            arlen_q     <= 8'd0;
            rem_q       <= '0;
            len_q       <= 5'd0;
            tag_q       <= '0;
            eof_q       <= 1'b0;
            bad_q       <= 1'b0;
            interr_q    <= 1'b0;
            slverr_q    <= 1'b0;
            decerr_q    <= 1'b0;
`ifdef ACP_MM2S_PARTIAL_EN
            btt_lo_q    <= 3'd0;
`endif
        end else begin
            state       <= state_nxt;
            cmd_ready_q <= (state_nxt == ST_IDLE);
            case (state)
                ST_IDLE: if (cmd_fire) begin
                    addr_q   <= cmd_saddr;
                    rem_q    <= cmd_beats;
                    tag_q    <= S_AXIS_CMD_TDATA[CMD_TAG_LSB +: CMD_TAG_W];
                    eof_q    <= S_AXIS_CMD_TDATA[CMD_EOF_BIT];
                    bad_q    <= cmd_bad;
`ifdef ACP_MM2S_PARTIAL_EN
                    btt_lo_q <= cmd_btt[2:0];
`endif
                end
                ST_CALC: if (bad_q) begin
                    interr_q <= 1'b1;
                end else begin
                    len_q    <= len_calc;
                    araddr_q <= addr_q;
                    arlen_q  <= {3'b000, len_calc} - 8'd1;
                end
                ST_DATA: if (r_fire) begin
                    rem_q <= rem_q - BEATS_W'(1);
                    if (M_AXI_RRESP == RRESP_SLVERR) slverr_q <= 1'b1;
                    if (M_AXI_RRESP == RRESP_DECERR) decerr_q <= 1'b1;
                    if (M_AXI_RLAST) addr_q <= addr_q + (C_M_AXI_ADDR_WIDTH'(len_q) << 3);
                end
                ST_STS: if (M_AXIS_STS_TREADY) begin
                    interr_q <= 1'b0;
                    slverr_q <= 1'b0;
                    decerr_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign S_AXIS_CMD_TREADY = cmd_ready_q;
    assign M_AXIS_STS_TVALID = (state == ST_STS);
    assign M_AXIS_STS_TDATA  = (state == ST_STS) ? sts_pack(tag_q, interr_q, decerr_q, slverr_q) : 8'h00;

    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARLEN   = arlen_q;
    assign M_AXI_ARSIZE  = 3'd3;
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARPROT  = C_PROT;
    assign M_AXI_ARCACHE = C_CACHE;
    assign M_AXI_ARVALID = (state == ST_ADDR);

    // R passes straight to the stream so backpressure reaches RREADY in the same cycle.
    assign M_AXI_RREADY  = (state == ST_DATA) && M_AXIS_TREADY;
    assign M_AXIS_TVALID = (state == ST_DATA) && M_AXI_RVALID;
    assign M_AXIS_TDATA  = M_AXI_RDATA;
    assign M_AXIS_TLAST  = (state == ST_DATA) && eof_q && last_beat;
`ifdef ACP_MM2S_PARTIAL_EN
    assign M_AXIS_TKEEP  = ((state == ST_DATA) && last_beat && (btt_lo_q != 3'd0)) ?
                           8'((9'd1 << btt_lo_q) - 9'd1) : 8'hFF;
`else
    assign M_AXIS_TKEEP  = 8'hFF;
`endif

endmodule

// File: tb/tb_acp_mm2s_engine.sv
// Directed scoreboard bench for acp_mm2s_engine with a simple ACP read slave.
module tb_acp_mm2s_engine;

    logic        clk, rst;
    logic [71:0] s_axis_cmd_tdata;
    logic        s_axis_cmd_tvalid, s_axis_cmd_tready;
    logic [7:0]  m_axis_sts_tdata;
    logic        m_axis_sts_tvalid, m_axis_sts_tready;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize, m_axi_arprot;
    logic [1:0]  m_axi_arburst, m_axi_rresp;
    logic [3:0]  m_axi_arcache;
    logic        m_axi_arvalid, m_axi_arready;
    logic [63:0] m_axi_rdata, m_axis_tdata;
    logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tlast, m_axis_tvalid, m_axis_tready;

    acp_mm2s_engine dut (
        .clk(clk), .rst(rst),
        .S_AXIS_CMD_TDATA(s_axis_cmd_tdata), .S_AXIS_CMD_TVALID(s_axis_cmd_tvalid),
        .S_AXIS_CMD_TREADY(s_axis_cmd_tready),
        .M_AXIS_STS_TDATA(m_axis_sts_tdata), .M_AXIS_STS_TVALID(m_axis_sts_tvalid),
        .M_AXIS_STS_TREADY(m_axis_sts_tready),
        .M_AXI_ARADDR(m_axi_araddr), .M_AXI_ARLEN(m_axi_arlen), .M_AXI_ARSIZE(m_axi_arsize),
        .M_AXI_ARBURST(m_axi_arburst), .M_AXI_ARPROT(m_axi_arprot), .M_AXI_ARCACHE(m_axi_arcache),
        .M_AXI_ARVALID(m_axi_arvalid), .M_AXI_ARREADY(m_axi_arready),
        .M_AXI_RDATA(m_axi_rdata), .M_AXI_RRESP(m_axi_rresp), .M_AXI_RLAST(m_axi_rlast),
        .M_AXI_RVALID(m_axi_rvalid), .M_AXI_RREADY(m_axi_rready),
        .M_AXIS_TDATA(m_axis_tdata), .M_AXIS_TKEEP(m_axis_tkeep), .M_AXIS_TLAST(m_axis_tlast),
        .M_AXIS_TVALID(m_axis_tvalid), .M_AXIS_TREADY(m_axis_tready)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int          tests = 0, fails = 0;
    int          beats_seen = 0, stall_cnt = 0;
    bit          chk_bp = 0;
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    logic [72:0] exp_q[$];    // {data, keep, last}
    logic [39:0] exp_ar[$];   // {addr, len}
    logic [7:0]  exp_sts[$];

    function automatic logic [63:0] mem_word(input logic [31:0] a);
        return {~a, a};
    endfunction

    task automatic check(input string name, input logic [72:0] act, input logic [72:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic report_fail(input string name, input logic [72:0] act);
        tests++;
        fails++;
        $display("FAIL %s: got %h, expected nothing", name, act);
    endtask

    // ---------------- monitors ----------------
    logic [72:0] mon_e;
    logic [39:0] ar_prev;
    bit          ar_wait = 0;

    always @(negedge clk) begin
        if (m_axis_tvalid && m_axis_tready) begin
            beats_seen++;
            if (exp_q.size() == 0) report_fail("unexpected_beat", {m_axis_tdata, m_axis_tkeep, m_axis_tlast});
            else begin
                mon_e = exp_q.pop_front();
                check("beat", {m_axis_tdata, m_axis_tkeep, m_axis_tlast}, mon_e);
            end
        end
        if (chk_bp && m_axis_tvalid) begin
            check("rready_follows_tready", 73'(m_axi_rready), 73'(m_axis_tready));
            if (!m_axi_rready) stall_cnt++;
        end
        if (ar_wait && m_axi_arvalid) check("ar_stable", 73'({m_axi_araddr, m_axi_arlen}), 73'(ar_prev));
        if (m_axi_arvalid && m_axi_arready) begin
            if (exp_ar.size() == 0) report_fail("unexpected_ar", 73'({m_axi_araddr, m_axi_arlen}));
            else check("ar", 73'({m_axi_araddr, m_axi_arlen}), 73'(exp_ar.pop_front()));
            check("ar_fixed", 73'({m_axi_arsize, m_axi_arburst, m_axi_arprot, m_axi_arcache}),
                  73'({3'd3, 2'b01, 3'b010, 4'b0011}));
        end
        ar_wait = m_axi_arvalid && !m_axi_arready;
        ar_prev = {m_axi_araddr, m_axi_arlen};
        if (m_axis_sts_tvalid && m_axis_sts_tready) begin
            if (exp_sts.size() == 0) report_fail("unexpected_sts", 73'(m_axis_sts_tdata));
            else check("sts", 73'(m_axis_sts_tdata), 73'(exp_sts.pop_front()));
        end
    end

    // ---------------- ACP read slave ----------------
    logic [31:0] q_addr[$];
    int          q_len[$];
    logic [31:0] b_addr, s_addr;
    int          b_len, b_beat, s_len;
    bit          busy, fa, fr, rs;

    initial begin
        busy = 0; b_addr = '0; b_len = 0; b_beat = 0;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0;
        m_axi_rresp = 2'b00; m_axi_rlast = 1'b0;
        forever begin
            @(negedge clk);
            fa = m_axi_arvalid && m_axi_arready;
            fr = m_axi_rvalid && m_axi_rready;
            rs = rst;
            s_addr = m_axi_araddr;
            s_len = int'(m_axi_arlen) + 1;
            @(posedge clk);
            #1;
            if (rs) begin
                q_addr.delete(); q_len.delete(); busy = 0;
            end else begin
                if (fa) begin q_addr.push_back(s_addr); q_len.push_back(s_len); end
                if (fr) begin b_beat++; if (b_beat == b_len) busy = 0; end
                if (!busy && q_addr.size() > 0) begin
                    b_addr = q_addr.pop_front(); b_len = q_len.pop_front(); b_beat = 0; busy = 1;
                end
            end
            m_axi_arready = rs ? 1'b0 : 1'($urandom_range(0, 1));
            m_axi_rvalid  = busy;
            m_axi_rdata   = mem_word(b_addr + 32'(b_beat * 8));
            m_axi_rlast   = busy && (b_beat == b_len - 1);
            m_axi_rresp   = (busy && (b_addr + 32'(b_beat * 8)) == err_addr) ? 2'b10 : 2'b00;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_cmd(input logic [22:0] btt, input logic [31:0] saddr,
                            input bit eof, input logic [3:0] tag);
        int n;
        @(posedge clk);
        #1;
        s_axis_cmd_tdata = '0;
        s_axis_cmd_tdata[22:0]  = btt;
        s_axis_cmd_tdata[23]    = 1'b1;
        s_axis_cmd_tdata[30]    = eof;
        s_axis_cmd_tdata[63:32] = saddr;
        s_axis_cmd_tdata[67:64] = tag;
        s_axis_cmd_tvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!s_axis_cmd_tready && n < 100);
        if (!s_axis_cmd_tready) report_fail("cmd_handshake_timeout", 73'(n));
        @(posedge clk);
        #1;
        s_axis_cmd_tvalid = 1'b0;
    endtask

    task automatic push_beats(input logic [31:0] saddr, input int n, input bit eof, input logic [7:0] last_keep);
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            a = saddr + 32'(i * 8);
            exp_q.push_back({mem_word(a), (i == n - 1) ? last_keep : 8'hFF, eof && (i == n - 1)});
        end
    endtask

    // Negedges from the command handshake cycle until ARVALID (which=0) or STS_TVALID (which=1).
    task automatic cycles_to(input string name, input int which, input int exp_n);
        int n;
        bit seen;
        n = 0; seen = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            seen = (which == 0) ? m_axi_arvalid : m_axis_sts_tvalid;
        end
        check(name, 73'(n), 73'(exp_n));
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((exp_sts.size() != 0 || exp_q.size() != 0 || exp_ar.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            report_fail(name, 73'({exp_ar.size(), exp_q.size()}));
            exp_q.delete(); exp_ar.delete(); exp_sts.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_beats(input int target);
        int n;
        n = 0;
        while (beats_seen < target && n < 500) begin @(negedge clk); n++; end
        if (beats_seen < target) report_fail("beat_wait_timeout", 73'(beats_seen));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valids"}, 73'({m_axi_arvalid, m_axi_rready, m_axis_tvalid, m_axis_sts_tvalid, s_axis_cmd_tready}), 73'(0));
        check({tag, "_ar"}, 73'({m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst}), 73'({32'h0, 8'h0, 3'd3, 2'b01}));
        check({tag, "_stream"}, 73'({m_axis_sts_tdata, m_axis_tkeep, m_axis_tlast}), 73'({8'h00, 8'hFF, 1'b0}));
    endtask

    // ---------------- directed tests ----------------
    int base;

    initial begin
        rst = 1'b1;
        s_axis_cmd_tdata = '0; s_axis_cmd_tvalid = 1'b0;
        m_axis_sts_tready = 1'b1; m_axis_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        #1;
        check("cmd_tready_before_clock", 73'(s_axis_cmd_tready), 73'(0));
        @(posedge clk);
        #1;
        check("cmd_tready_after_clock", 73'(s_axis_cmd_tready), 73'(1));

        // Single burst, status held under backpressure then taken in one cycle.
        m_axis_sts_tready = 1'b0;
        exp_ar.push_back({32'h0000_1000, 8'd7});
        push_beats(32'h0000_1000, 8, 1'b1, 8'hFF);
        exp_sts.push_back(8'h85);
        send_cmd(23'd64, 32'h0000_1000, 1'b1, 4'd5);
        cycles_to("single_ar_latency", 0, 2);
        base = 0;
        while (!m_axis_sts_tvalid && base < 200) begin @(negedge clk); base++; end
        repeat (3) @(negedge clk);
        check("sts_held", 73'({m_axis_sts_tvalid, m_axis_sts_tdata}), 73'({1'b1, 8'h85}));
        @(posedge clk);
        #1;
        m_axis_sts_tready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("sts_one_cycle", 73'({m_axis_sts_tvalid, s_axis_cmd_tready}), 73'({1'b0, 1'b1}));
        wait_done("single_done");

        // 4 KB split.
        exp_ar.push_back({32'h0000_0FC0, 8'd7});
        exp_ar.push_back({32'h0000_1000, 8'd15});
        exp_ar.push_back({32'h0000_1080, 8'd7});
        push_beats(32'h0000_0FC0, 32, 1'b1, 8'hFF);
        exp_sts.push_back(8'h82);
        send_cmd(23'd256, 32'h0000_0FC0, 1'b1, 4'd2);
        wait_done("split_done");

        // Invalid commands: zero length and misaligned address.
        exp_sts.push_back(8'h13);
        send_cmd(23'd0, 32'h0000_1000, 1'b1, 4'd3);
        cycles_to("invalid_sts_latency", 1, 2);
        wait_done("invalid_done");
        exp_sts.push_back(8'h17);
        send_cmd(23'd8, 32'h0000_1004, 1'b1, 4'd7);
        wait_done("misaligned_done");

        // SLVERR on beat 3; data still forwarded.
        err_addr = 32'h0000_2010;
        exp_ar.push_back({32'h0000_2000, 8'd7});
        push_beats(32'h0000_2000, 8, 1'b1, 8'hFF);
        exp_sts.push_back(8'h41);
        send_cmd(23'd64, 32'h0000_2000, 1'b1, 4'd1);
        wait_done("slverr_done");
        err_addr = 32'hFFFF_FFFF;

        // Stream backpressure mid-burst, EOF=0.
        exp_ar.push_back({32'h0000_3000, 8'd15});
        push_beats(32'h0000_3000, 16, 1'b0, 8'hFF);
        exp_sts.push_back(8'h84);
        base = beats_seen;
        send_cmd(23'd128, 32'h0000_3000, 1'b0, 4'd4);
        wait_beats(base + 4);
        @(posedge clk);
        #1;
        stall_cnt = 0;
        chk_bp = 1'b1;
        m_axis_tready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        m_axis_tready = 1'b1;
        @(negedge clk);
        #1;
        chk_bp = 1'b0;
        check("stall_cycles", 73'(stall_cnt), 73'(5));
        wait_done("backpressure_done");

        // Reset in the middle of DATA.
        exp_ar.push_back({32'h0000_4000, 8'd15});
        push_beats(32'h0000_4000, 16, 1'b1, 8'hFF);
        base = beats_seen;
        send_cmd(23'd128, 32'h0000_4000, 1'b1, 4'd9);
        wait_beats(base + 3);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        exp_q.delete(); exp_ar.delete(); exp_sts.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("cmd_tready_after_reset", 73'(s_axis_cmd_tready), 73'(1));
        repeat (2) @(negedge clk);

        // BTT=13: partial final beat with the macro, rejected without it.
`ifdef ACP_MM2S_PARTIAL_EN
        exp_ar.push_back({32'h0000_5000, 8'd1});
        push_beats(32'h0000_5000, 2, 1'b1, 8'h1F);
        exp_sts.push_back(8'h86);
`else
        exp_sts.push_back(8'h16);
`endif
        send_cmd(23'd13, 32'h0000_5000, 1'b1, 4'd6);
        wait_done("partial_done");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
